// File: rtl/calc2_port_sched_if.sv
// calc2_port_sched_if: bundles the client request/response channel and the
// calc2 request/response port of one calc2_port_sched instance.
//   req_*      client request (valid/ready handshake)
//   rsp_*      client response pulse (no back-pressure)
//   calc_*_out command stream towards calc2 (two-cycle protocol)
//   calc_*_in  response stream from calc2
//   busy_tags  outstanding-tag bitmap, err_spurious sticky error
// Modports: slave = scheduler side, master = client/calc2 side.
interface calc2_port_sched_if #(
    parameter int unsigned ID_W = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_cmd;
    logic [31:0]     req_op1;
    logic [31:0]     req_op2;
    logic [ID_W-1:0] req_id;

    logic [3:0]      calc_cmd_out;
    logic [31:0]     calc_data_out;
    logic [1:0]      calc_tag_out;
    logic [1:0]      calc_resp_in;
    logic [31:0]     calc_data_in;
    logic [1:0]      calc_tag_in;

    logic            rsp_valid;
    logic [1:0]      rsp_code;
    logic [31:0]     rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic [3:0]      busy_tags;
    logic            err_spurious;

    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2, req_id,
        input  calc_resp_in, calc_data_in, calc_tag_in,
        output req_ready,
        output calc_cmd_out, calc_data_out, calc_tag_out,
        output rsp_valid, rsp_code, rsp_data, rsp_id, busy_tags, err_spurious
    );

    modport master (
        output req_valid, req_cmd, req_op1, req_op2, req_id,
        output calc_resp_in, calc_data_in, calc_tag_in,
        input  req_ready,
        input  calc_cmd_out, calc_data_out, calc_tag_out,
        input  rsp_valid, rsp_code, rsp_data, rsp_id, busy_tags, err_spurious
    );
endinterface

// File: rtl/calc2_port_sched.sv
// calc2_port_sched: per-port request scheduler between one client and one
// calc2 request/response port.
//   - accepts two-operand commands (valid/ready), allocates the lowest free
//     2-bit tag and serialises the command as OP1 (cmd/op1/tag) then OP2 (op2)
//   - tracks up to 4 outstanding tags, maps calc2 responses back to client IDs
//   - retires tags that get no response within TIMEOUT_CYC cycles (code 0)
// Ports:
//   c_clk   clock, rising edge
//   reset   synchronous active-low reset
//   bus     calc2_port_sched_if.slave (client request/response + calc2 port)
module calc2_port_sched #(
    parameter int unsigned ID_W        = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic                c_clk,
    input logic                reset,
    calc2_port_sched_if.slave  bus
);

    localparam logic [7:0] TimerLoad = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StOp1, StOp2} state_e;

    state_e          state_q, state_d;

    logic [3:0]      busy_q, busy_d;
    logic [ID_W-1:0] id_tab_q [4];
    logic [7:0]      timer_q  [4];
    logic [7:0]      timer_d  [4];
    logic [31:0]     op2_q;

    logic [3:0]      calc_cmd_q, calc_cmd_d;
    logic [31:0]     calc_data_q, calc_data_d;
    logic [1:0]      calc_tag_q, calc_tag_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [1:0]      rsp_code_q, rsp_code_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            err_q, err_d;

    logic            ready;
    logic            hs;
    logic [1:0]      alloc_tag;
    logic            rsp_hit;
    logic            spurious;
    logic [3:0]      expired;
    logic            to_valid;
    logic [1:0]      to_tag;

    // Ready and tag choice only look at registered busy_q, so a tag freed this
    // cycle cannot be re-allocated before the next one.
    assign ready = reset && (state_q == StIdle || state_q == StOp2) && (busy_q != 4'hF);
    assign hs    = bus.req_valid && ready;

    always_comb begin
        alloc_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_tag = 2'(i);
            end
        end
    end

    assign rsp_hit  = (bus.calc_resp_in != 2'd0) && busy_q[bus.calc_tag_in];
    assign spurious = (bus.calc_resp_in != 2'd0) && !busy_q[bus.calc_tag_in];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            expired[i] = busy_q[i] && (timer_q[i] == 8'd0);
        end
    end

    // A real calc2 response always takes the response slot; timeouts wait.
    assign to_valid = (expired != 4'd0) && !rsp_hit;

    always_comb begin
        to_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (expired[i]) begin
                to_tag = 2'(i);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = hs ? StOp1 : StIdle;
            StOp1:   state_d = StOp2;
            StOp2:   state_d = hs ? StOp1 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: next value of the registered calc2 command outputs
    always_comb begin
        calc_cmd_d  = 4'd0;
        calc_data_d = 32'd0;
        calc_tag_d  = 2'd0;
        if (hs) begin
            calc_cmd_d  = bus.req_cmd;
            calc_data_d = bus.req_op1;
            calc_tag_d  = alloc_tag;
        end else if (state_q == StOp1) begin
            calc_data_d = op2_q;
        end
    end

    // Tag bookkeeping: at most one free (response or timeout) and one
    // allocation per cycle, never on the same tag.
    always_comb begin
        busy_d = busy_q;
        if (rsp_hit) begin
            busy_d[bus.calc_tag_in] = 1'b0;
        end else if (to_valid) begin
            busy_d[to_tag] = 1'b0;
        end
        if (hs) begin
            busy_d[alloc_tag] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            timer_d[i] = timer_q[i];
            if (hs && alloc_tag == 2'(i)) begin
                timer_d[i] = TimerLoad;
            end else if (busy_q[i] && timer_q[i] != 8'd0) begin
                timer_d[i] = timer_q[i] - 8'd1;
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_hit || to_valid;
        rsp_code_d  = 2'd0;
        rsp_data_d  = 32'd0;
        rsp_id_d    = '0;
        if (rsp_hit) begin
            rsp_code_d = bus.calc_resp_in;
            rsp_data_d = bus.calc_data_in;
            rsp_id_d   = id_tab_q[bus.calc_tag_in];
        end else if (to_valid) begin
            rsp_id_d = id_tab_q[to_tag];
        end
        err_d = err_q || spurious;
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            busy_q      <= 4'd0;
            op2_q       <= 32'd0;
            calc_cmd_q  <= 4'd0;
            calc_data_q <= 32'd0;
            calc_tag_q  <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= 2'd0;
            rsp_data_q  <= 32'd0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                id_tab_q[i] <= '0;
                timer_q[i]  <= 8'd0;
            end
        end else begin
            busy_q      <= busy_d;
            calc_cmd_q  <= calc_cmd_d;
            calc_data_q <= calc_data_d;
            calc_tag_q  <= calc_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            err_q       <= err_d;
            for (int i = 0; i < 4; i++) begin
                timer_q[i] <= timer_d[i];
            end
            if (hs) begin
                op2_q               <= bus.req_op2;
                id_tab_q[alloc_tag] <= bus.req_id;
            end
        end
    end

    assign bus.req_ready     = ready;
    assign bus.calc_cmd_out  = calc_cmd_q;
    assign bus.calc_data_out = calc_data_q;
    assign bus.calc_tag_out  = calc_tag_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_code      = rsp_code_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.busy_tags     = busy_q;
    assign bus.err_spurious  = err_q;

endmodule

// File: tb/tb_calc2_port_sched.sv
// Directed bench for calc2_port_sched. dut_a uses a long timeout so the
// handshake/ordering scenarios are not disturbed; dut_b uses TIMEOUT_CYC=8
// for the timeout scenarios.
module tb_calc2_port_sched;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 c_clk = ~c_clk;

    calc2_port_sched_if #(.ID_W(4)) ifa ();
    calc2_port_sched_if #(.ID_W(4)) ifb ();

    calc2_port_sched #(.ID_W(4), .TIMEOUT_CYC(64)) dut_a (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    calc2_port_sched #(.ID_W(4), .TIMEOUT_CYC(8)) dut_b (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold req_valid on dut_a until n requests are accepted; IDs id0, id0+1, ...
    task automatic issue_a(input int n, input logic [3:0] id0);
        int   k = 0;
        int   budget = 0;
        logic hs;
        ifa.req_valid = 1'b1;
        ifa.req_cmd   = 4'd1;
        ifa.req_op1   = 32'h0000_00A0;
        ifa.req_op2   = 32'h0000_00B0;
        ifa.req_id    = id0;
        while (k < n && budget < 50) begin
            hs = ifa.req_ready;
            tick();
            budget++;
            if (hs) begin
                k++;
                ifa.req_id = id0 + 4'(k);
            end
        end
        ifa.req_valid = 1'b0;
        check("issue_count", 64'(k), 64'(n));
    endtask

    logic [1:0]  ord  [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
    logic [31:0] dat  [4] = '{32'h0000_0333, 32'h0000_0111, 32'h0000_0222, 32'h0000_0444};
    logic [3:0]  eids [4] = '{4'd4, 4'd1, 4'd3, 4'd2};
    logic [3:0]  cids [4] = '{4'd1, 4'd2, 4'd5, 4'd4};

    int          seen;
    logic [63:0] s_code, s_data, s_id;

    initial begin
        ifa.req_valid = 0; ifa.req_cmd = 0; ifa.req_op1 = 0; ifa.req_op2 = 0; ifa.req_id = 0;
        ifa.calc_resp_in = 0; ifa.calc_data_in = 0; ifa.calc_tag_in = 0;
        ifb.req_valid = 0; ifb.req_cmd = 0; ifb.req_op1 = 0; ifb.req_op2 = 0; ifb.req_id = 0;
        ifb.calc_resp_in = 0; ifb.calc_data_in = 0; ifb.calc_tag_in = 0;

        // Reset state
        tick();
        tick();
        check("rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
        check("rst_busy", 64'(ifa.busy_tags), 64'd0);
        check("rst_calc_cmd", 64'(ifa.calc_cmd_out), 64'd0);
        check("rst_err", 64'(ifa.err_spurious), 64'd0);
        check("rst_ready", 64'(ifa.req_ready), 64'd0);
        reset = 1'b1;
        tick();
        check("ready_after_rst", 64'(ifa.req_ready), 64'd1);

        // Single add
        ifa.req_valid = 1; ifa.req_cmd = 4'd1; ifa.req_op1 = 32'd5; ifa.req_op2 = 32'd3;
        ifa.req_id = 4'hA;
        tick();
        ifa.req_valid = 0;
        check("add_op1_cmd", 64'(ifa.calc_cmd_out), 64'd1);
        check("add_op1_data", 64'(ifa.calc_data_out), 64'd5);
        check("add_op1_tag", 64'(ifa.calc_tag_out), 64'd0);
        check("add_busy", 64'(ifa.busy_tags), 64'h1);
        tick();
        check("add_op2_cmd", 64'(ifa.calc_cmd_out), 64'd0);
        check("add_op2_data", 64'(ifa.calc_data_out), 64'd3);
        tick();
        check("add_idle_data", 64'(ifa.calc_data_out), 64'd0);
        ifa.calc_resp_in = 2'd1; ifa.calc_data_in = 32'd8; ifa.calc_tag_in = 2'd0;
        tick();
        ifa.calc_resp_in = 2'd0;
        check("add_rsp_valid", 64'(ifa.rsp_valid), 64'd1);
        check("add_rsp_code", 64'(ifa.rsp_code), 64'd1);
        check("add_rsp_data", 64'(ifa.rsp_data), 64'd8);
        check("add_rsp_id", 64'(ifa.rsp_id), 64'hA);
        check("add_busy_clr", 64'(ifa.busy_tags), 64'd0);
        tick();
        check("add_rsp_pulse", 64'(ifa.rsp_valid), 64'd0);

        // Five back-to-back requests, valid held
        ifa.req_valid = 1; ifa.req_cmd = 4'd2; ifa.req_op1 = 32'h10; ifa.req_op2 = 32'h20;
        ifa.req_id = 4'd1;
        check("b2b_ready0", 64'(ifa.req_ready), 64'd1);
        tick();
        check("b2b_tag0", 64'(ifa.calc_tag_out), 64'd0);
        check("b2b_cmd0", 64'(ifa.calc_cmd_out), 64'd2);
        check("b2b_ready_op1", 64'(ifa.req_ready), 64'd0);
        ifa.req_id = 4'd2;
        tick();
        check("b2b_op2_data", 64'(ifa.calc_data_out), 64'h20);
        tick();
        check("b2b_tag1", 64'(ifa.calc_tag_out), 64'd1);
        check("b2b_busy1", 64'(ifa.busy_tags), 64'h3);
        ifa.req_id = 4'd3;
        tick();
        tick();
        check("b2b_tag2", 64'(ifa.calc_tag_out), 64'd2);
        check("b2b_busy2", 64'(ifa.busy_tags), 64'h7);
        ifa.req_id = 4'd4;
        tick();
        tick();
        check("b2b_tag3", 64'(ifa.calc_tag_out), 64'd3);
        check("b2b_busy3", 64'(ifa.busy_tags), 64'hF);
        ifa.req_id = 4'd5;
        tick();
        check("b2b_full_ready_op2", 64'(ifa.req_ready), 64'd0);
        tick();
        check("b2b_full_ready_idle", 64'(ifa.req_ready), 64'd0);
        check("b2b_idle_cmd", 64'(ifa.calc_cmd_out), 64'd0);
        ifa.calc_resp_in = 2'd1; ifa.calc_data_in = 32'h77; ifa.calc_tag_in = 2'd2;
        tick();
        ifa.calc_resp_in = 2'd0;
        check("b2b_rsp_valid", 64'(ifa.rsp_valid), 64'd1);
        check("b2b_rsp_id", 64'(ifa.rsp_id), 64'd3);
        check("b2b_rsp_data", 64'(ifa.rsp_data), 64'h77);
        check("b2b_busy_free", 64'(ifa.busy_tags), 64'hB);
        check("b2b_ready_again", 64'(ifa.req_ready), 64'd1);
        tick();
        ifa.req_valid = 0;
        check("b2b_tag_reuse", 64'(ifa.calc_tag_out), 64'd2);
        check("b2b_busy_full2", 64'(ifa.busy_tags), 64'hF);

        // Drain tags 0..3 in order
        for (int i = 0; i < 4; i++) begin
            ifa.calc_resp_in = 2'd1; ifa.calc_data_in = 32'(i); ifa.calc_tag_in = 2'(i);
            tick();
            ifa.calc_resp_in = 2'd0;
            check("drain_valid", 64'(ifa.rsp_valid), 64'd1);
            check("drain_id", 64'(ifa.rsp_id), 64'(cids[i]));
        end
        check("drain_busy", 64'(ifa.busy_tags), 64'd0);

        // Out-of-order responses
        issue_a(4, 4'd1);
        check("ooo_busy", 64'(ifa.busy_tags), 64'hF);
        for (int i = 0; i < 4; i++) begin
            ifa.calc_resp_in = 2'd1; ifa.calc_data_in = dat[i]; ifa.calc_tag_in = ord[i];
            tick();
            ifa.calc_resp_in = 2'd0;
            check("ooo_valid", 64'(ifa.rsp_valid), 64'd1);
            check("ooo_id", 64'(ifa.rsp_id), 64'(eids[i]));
            check("ooo_data", 64'(ifa.rsp_data), 64'(dat[i]));
        end
        check("ooo_busy_clr", 64'(ifa.busy_tags), 64'd0);
        tick();
        tick();

        // Timeout on dut_b (TIMEOUT_CYC=8)
        ifb.req_valid = 1; ifb.req_cmd = 4'd5; ifb.req_op1 = 32'h1; ifb.req_op2 = 32'h2;
        ifb.req_id = 4'd6;
        tick();
        ifb.req_valid = 0;
        check("to_op1_tag", 64'(ifb.calc_tag_out), 64'd0);
        seen = -1; s_code = '1; s_data = '1; s_id = '1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (ifb.rsp_valid && seen < 0) begin
                seen = c;
                s_code = 64'(ifb.rsp_code);
                s_data = 64'(ifb.rsp_data);
                s_id = 64'(ifb.rsp_id);
            end
        end
        check("to_latency", 64'(seen), 64'd9);
        check("to_code", s_code, 64'd0);
        check("to_data", s_data, 64'd0);
        check("to_id", s_id, 64'd6);
        check("to_busy_clr", 64'(ifb.busy_tags), 64'd0);
        check("to_err_before", 64'(ifb.err_spurious), 64'd0);
        ifb.calc_resp_in = 2'd1; ifb.calc_data_in = 32'h9; ifb.calc_tag_in = 2'd0;
        tick();
        ifb.calc_resp_in = 2'd0;
        check("spur_no_rsp", 64'(ifb.rsp_valid), 64'd0);
        check("spur_err", 64'(ifb.err_spurious), 64'd1);
        tick();

        // Timeout expiry coinciding with a response on another tag
        ifb.req_valid = 1; ifb.req_id = 4'd7;
        tick();
        ifb.req_id = 4'd8;
        tick();
        tick();
        ifb.req_valid = 0;
        check("mix_tag1", 64'(ifb.calc_tag_out), 64'd1);
        repeat (6) tick();
        check("mix_pre_valid", 64'(ifb.rsp_valid), 64'd0);
        check("mix_pre_busy", 64'(ifb.busy_tags), 64'h3);
        ifb.calc_resp_in = 2'd2; ifb.calc_data_in = 32'h55; ifb.calc_tag_in = 2'd1;
        tick();
        ifb.calc_resp_in = 2'd0;
        check("mix_rsp1_valid", 64'(ifb.rsp_valid), 64'd1);
        check("mix_rsp1_code", 64'(ifb.rsp_code), 64'd2);
        check("mix_rsp1_id", 64'(ifb.rsp_id), 64'd8);
        check("mix_rsp1_data", 64'(ifb.rsp_data), 64'h55);
        tick();
        check("mix_to_valid", 64'(ifb.rsp_valid), 64'd1);
        check("mix_to_code", 64'(ifb.rsp_code), 64'd0);
        check("mix_to_id", 64'(ifb.rsp_id), 64'd7);
        check("mix_busy_clr", 64'(ifb.busy_tags), 64'd0);

        // Reset during OP2 with two tags busy on dut_a
        issue_a(2, 4'd9);
        tick();
        check("mr_busy", 64'(ifa.busy_tags), 64'h3);
        check("mr_op2_data", 64'(ifa.calc_data_out), 64'hB0);
        reset = 1'b0;
        tick();
        check("mr_busy_clr", 64'(ifa.busy_tags), 64'd0);
        check("mr_calc_data", 64'(ifa.calc_data_out), 64'd0);
        check("mr_calc_cmd", 64'(ifa.calc_cmd_out), 64'd0);
        check("mr_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
        check("mr_ready", 64'(ifa.req_ready), 64'd0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mr_no_rsp", 64'(ifa.rsp_valid), 64'd0);
        end
        issue_a(1, 4'd11);
        check("mr_first_tag", 64'(ifa.calc_tag_out), 64'd0);
        check("mr_first_busy", 64'(ifa.busy_tags), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
